// File: rtl/keypad_key_capture.sv
// keypad_key_capture: debounces the scanner's key_pressed/value pair, records
// one key event per physical press, keeps the last two hex digits and
// time-multiplexes them onto a dual common-anode seven-segment display.
module keypad_key_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned MUX_CYCLES      = 2048
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_pressed,
  input  logic [3:0] value,
  output logic       key_valid,
  output logic [3:0] new_digit,
  output logic [3:0] old_digit,
  output logic [6:0] seg,
  output logic [1:0] an_n
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned MW = $clog2(MUX_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_t;

  state_t          state;
  logic [DW-1:0]   dcnt;
  logic [3:0]      candidate;
  logic [MW-1:0]   mcnt;
  logic [3:0]      shown;

  // Key FSM: debounce press, latch digit once, debounce release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dcnt      <= '0;
      candidate <= 4'h0;
      new_digit <= 4'h0;
      old_digit <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (key_pressed) begin
            candidate <= value;
            dcnt      <= '0;
            state     <= DB_PRESS;
          end
        end
        DB_PRESS: begin
          if (!key_pressed || (value != candidate)) begin
            state <= IDLE;
          end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            old_digit <= new_digit;
            new_digit <= candidate;
            key_valid <= 1'b1;
            state     <= HELD;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        HELD: begin
          if (!key_pressed) begin
            dcnt  <= '0;
            state <= DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (key_pressed) begin
            state <= HELD;
          end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display mux: alternate the enabled digit every MUX_CYCLES clocks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt <= '0;
      an_n <= 2'b10;
    end else if (mcnt == MW'(MUX_CYCLES - 1)) begin
      mcnt <= '0;
      an_n <= ~an_n;
    end else begin
      mcnt <= mcnt + MW'(1);
    end
  end

  // Active-low hex decode of the currently enabled digit
  always_comb begin
    shown = (an_n[0] == 1'b0) ? new_digit : old_digit;
    seg   = 7'b1111111;
    case (shown)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_keypad_key_capture.sv
// Testbench for keypad_key_capture: directed test-plan scenarios followed by
// randomized press/release traffic, all checked against a behavioural model.
module tb_keypad_key_capture;

  localparam int DB = 4;
  localparam int MX = 8;

  localparam logic [6:0] HEX7 [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_pressed = 1'b0;
  logic [3:0] value = 4'h0;
  logic       key_valid;
  logic [3:0] new_digit;
  logic [3:0] old_digit;
  logic [6:0] seg;
  logic [1:0] an_n;

  always #5 clk = ~clk;

  keypad_key_capture #(
    .DEBOUNCE_CYCLES(DB),
    .MUX_CYCLES(MX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_pressed(key_pressed),
    .value(value),
    .key_valid(key_valid),
    .new_digit(new_digit),
    .old_digit(old_digit),
    .seg(seg),
    .an_n(an_n)
  );

  int n_pass = 0;
  int n_total = 0;
  int dut_pulses = 0;

  // Behavioural model: "locked" means a key has been accepted and we wait
  // for a debounced release; streak counts qualifying consecutive samples.
  bit         locked;
  int         streak;
  logic [3:0] cand;
  logic [3:0] m_new;
  logic [3:0] m_old;
  logic       m_valid;
  int         edges;

  task automatic model_reset();
    locked  = 1'b0;
    streak  = 0;
    cand    = 4'h0;
    m_new   = 4'h0;
    m_old   = 4'h0;
    m_valid = 1'b0;
    edges   = 0;
  endtask

  task automatic model_step();
    m_valid = 1'b0;
    edges++;
    if (!locked) begin
      if (streak == 0) begin
        if (key_pressed) begin
          cand   = value;
          streak = 1;
        end
      end else if (key_pressed && value == cand) begin
        streak++;
        if (streak == DB + 1) begin
          m_valid = 1'b1;
          m_old   = m_new;
          m_new   = cand;
          locked  = 1'b1;
          streak  = 0;
        end
      end else begin
        streak = 0;
      end
    end else begin
      if (key_pressed) begin
        streak = 0;
      end else begin
        streak++;
        if (streak == DB + 1) begin
          locked = 1'b0;
          streak = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    exp_an  = (((edges / MX) % 2) == 0) ? 2'b10 : 2'b01;
    exp_seg = (exp_an == 2'b10) ? HEX7[m_new] : HEX7[m_old];
    if (key_valid === 1'b1) dut_pulses++;
    chk({tag, ".key_valid"}, 32'(key_valid), 32'(m_valid));
    chk({tag, ".new_digit"}, 32'(new_digit), 32'(m_new));
    chk({tag, ".old_digit"}, 32'(old_digit), 32'(m_old));
    chk({tag, ".an_n"}, 32'(an_n), 32'(exp_an));
    chk({tag, ".seg"}, 32'(seg), 32'(exp_seg));
  endtask

  // One clock: drive inputs, let the edge happen, check half a cycle later
  task automatic step(input logic kp, input logic [3:0] v, input string tag);
    key_pressed = kp;
    value       = v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  // Reset pulse starting at a falling edge; clear must be visible before any clk edge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    chk({tag, ".seg0"}, 32'(seg), 32'(7'b1000000));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all({tag, ".held"});
  endtask

  initial begin
    int p0;
    int len;
    logic kp;
    logic [3:0] v;

    model_reset();
    @(negedge clk);

    // Reset
    do_reset("reset");

    // Clean press of A held for 10 cycles
    p0 = dut_pulses;
    for (int i = 0; i < 10; i++) step(1'b1, 4'hA, "clean");
    chk("clean.new", 32'(new_digit), 32'h0A);
    chk("clean.old", 32'(old_digit), 32'h00);
    chk("clean.pulses", 32'(dut_pulses - p0), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 4'h0, "clean_rel");

    // Press bounce never reaches acceptance
    p0 = dut_pulses;
    for (int r = 0; r < 3; r++) begin
      step(1'b1, 4'h3, "bounce");
      step(1'b1, 4'h3, "bounce");
      step(1'b0, 4'h3, "bounce");
    end
    for (int i = 0; i < 6; i++) step(1'b0, 4'h0, "bounce_rel");
    chk("bounce.pulses", 32'(dut_pulses - p0), 32'd0);
    chk("bounce.new", 32'(new_digit), 32'h0A);

    // Two keys from a clean reset
    @(negedge clk);
    do_reset("reset2");
    p0 = dut_pulses;
    for (int i = 0; i < 6; i++) step(1'b1, 4'h1, "two_k1");
    for (int i = 0; i < 6; i++) step(1'b0, 4'h0, "two_rel");
    for (int i = 0; i < 6; i++) step(1'b1, 4'hA, "two_kA");
    chk("two.pulses", 32'(dut_pulses - p0), 32'd2);
    chk("two.new", 32'(new_digit), 32'h0A);
    chk("two.old", 32'(old_digit), 32'h01);
    for (int i = 0; i < 2 * MX; i++) begin
      step(1'b1, 4'hA, "two_hold");
      if (an_n == 2'b01) chk("two.seg_left", 32'(seg), 32'(7'b1111001));
      else chk("two.seg_right", 32'(seg), 32'(7'b0001000));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 4'h0, "two_rel2");

    // Release bounce and value glitch while holding 5
    p0 = dut_pulses;
    for (int i = 0; i < 6; i++) step(1'b1, 4'h5, "rb_hold");
    step(1'b0, 4'h5, "rb_drop");
    step(1'b0, 4'h5, "rb_drop");
    for (int i = 0; i < 3; i++) step(1'b1, 4'h5, "rb_restore");
    for (int i = 0; i < 3; i++) step(1'b1, 4'h7, "rb_glitch");
    chk("rb.pulses", 32'(dut_pulses - p0), 32'd1);
    chk("rb.new", 32'(new_digit), 32'h05);
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, "rb_rel");
    for (int i = 0; i < 6; i++) step(1'b1, 4'h5, "rb_again");
    chk("rb.pulses2", 32'(dut_pulses - p0), 32'd2);
    chk("rb.new2", 32'(new_digit), 32'h05);
    chk("rb.old2", 32'(old_digit), 32'h05);
    for (int i = 0; i < 6; i++) step(1'b0, 4'h0, "rb_rel2");

    // Reset in the middle of a press debounce, key kept held
    step(1'b1, 4'h3, "mid_press");
    step(1'b1, 4'h3, "mid_press");
    step(1'b1, 4'h3, "mid_press");
    do_reset("mid_reset");
    for (int i = 0; i < 4; i++) step(1'b1, 4'h3, "mid_after");
    chk("mid.new_before", 32'(new_digit), 32'h00);
    step(1'b1, 4'h3, "mid_event");
    chk("mid.new", 32'(new_digit), 32'h03);
    chk("mid.valid", 32'(key_valid), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 4'h0, "mid_rel");

    // Randomized press/release/glitch traffic
    for (int s = 0; s < 80; s++) begin
      kp  = 1'($urandom_range(0, 1));
      v   = 4'($urandom_range(0, 15));
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) v = 4'($urandom_range(0, 15));
        step(kp, v, "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
